// File: rtl/led_decoder_seq.sv
// Registered SEL_W-to-2**SEL_W LED decoder with scan, bounce and blink display modes.
// Define LED_ACTIVE_HIGH_EN to drive the LEDs active-high (lit = 1, idle = all zeros).
module led_decoder_seq #(
    parameter int          SEL_W     = 3,
    parameter int          PRESCALE  = 4,
    parameter logic [2:0]  EN_ACTIVE = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           enable,
    input  logic [SEL_W-1:0]     switch,
    input  logic [1:0]           mode,
    output logic [(1<<SEL_W)-1:0] led,
    output logic [SEL_W-1:0]     pos,
    output logic                 wrap
);

    localparam int N     = 1 << SEL_W;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] POS_MAX  = {SEL_W{1'b1}};

`ifdef LED_ACTIVE_HIGH_EN
    localparam logic [N-1:0] LED_OFF = '0;
`else
    localparam logic [N-1:0] LED_OFF = '1;
`endif

    typedef enum logic [1:0] {
        M_DIRECT = 2'd0,
        M_SCAN   = 2'd1,
        M_BOUNCE = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    // LED drive pattern with exactly one LED lit at index idx, in board polarity.
    function automatic logic [N-1:0] light(input logic [SEL_W-1:0] idx);
        logic [N-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
`ifdef LED_ACTIVE_HIGH_EN
        return onehot;
`else
        return ~onehot;
`endif
    endfunction

    mode_t             mode_q, mode_d;
    dir_t              dir_q, dir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [SEL_W-1:0]  pos_q, pos_d;
    logic [N-1:0]      led_q, led_d;
    logic              wrap_q, wrap_d;
    logic              active;
    logic              tick;

    assign active = (enable == EN_ACTIVE);
    assign tick   = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        mode_d  = mode_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        led_d   = LED_OFF;
        wrap_d  = 1'b0;

        if (active) begin
            if (mode_t'(mode) != mode_q) begin
                // A mode switch restarts the animation from the switch position, without stepping.
                mode_d  = mode_t'(mode);
                pos_d   = switch;
                dir_d   = DIR_UP;
                cnt_d   = '0;
                phase_d = 1'b1;
                led_d   = light(switch);
            end else begin
                if (mode_q != M_DIRECT) begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                end
                unique case (mode_q)
                    M_DIRECT: begin
                        pos_d = switch;
                        led_d = light(switch);
                    end
                    M_SCAN: begin
                        if (tick) begin
                            pos_d  = pos_q + 1'b1;
                            wrap_d = (pos_q == POS_MAX);
                        end
                        led_d = light(pos_d);
                    end
                    M_BOUNCE: begin
                        // Reversal happens in place of a step, so each end stays lit for one step.
                        if (tick) begin
                            if (dir_q == DIR_UP) begin
                                if (pos_q == POS_MAX) begin
                                    pos_d  = POS_MAX - 1'b1;
                                    dir_d  = DIR_DOWN;
                                    wrap_d = 1'b1;
                                end else begin
                                    pos_d = pos_q + 1'b1;
                                end
                            end else begin
                                if (pos_q == '0) begin
                                    pos_d  = SEL_W'(1);
                                    dir_d  = DIR_UP;
                                    wrap_d = 1'b1;
                                end else begin
                                    pos_d = pos_q - 1'b1;
                                end
                            end
                        end
                        led_d = light(pos_d);
                    end
                    M_BLINK: begin
                        pos_d = switch;
                        if (tick) begin
                            phase_d = ~phase_q;
                        end
                        led_d = phase_d ? light(switch) : LED_OFF;
                    end
                    default: begin
                        led_d = LED_OFF;
                    end
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= M_DIRECT;
            dir_q   <= DIR_UP;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            pos_q   <= '0;
            led_q   <= LED_OFF;
            wrap_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            led_q   <= led_d;
            wrap_q  <= wrap_d;
        end
    end

    assign led  = led_q;
    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule
